uart_tx_arbiter: RTL and testbench

- Shares one UartTx serializer among NUM_REQ byte producers (e.g. echo thread, status reporter, debug dumper) inside blinkled-class designs.
- Performs round-robin selection among requesters, latches the winning byte and drives the UartTx enable/ready sequence.
- Holds off further grants until the serializer reports ready again, so no byte is ever dropped or overwritten.

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx serializer among NUM_REQ byte producers.
// Latency: request accepted in the same cycle (IDLE, tx_ready=1); tx_enable pulses 2 cycles later.
// Backpressure: no grant until the serializer reports ready again; requesters hold valid until accepted.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_din,
  output logic                   tx_enable,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic [15:0]            sent_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [7:0]     tx_din_q;
  logic           tx_enable_q;
  logic           busy_q;
  logic [IDW-1:0] grant_id_q;
  logic [15:0]    sent_count_q;

  // Candidate at or above the pointer (hi) and lowest overall (lo, used on wrap)
  logic           hi_vld;
  logic [IDW-1:0] hi_idx;
  logic [7:0]     hi_dat;
  logic           lo_vld;
  logic [IDW-1:0] lo_idx;
  logic [7:0]     lo_dat;

  logic           sel_vld;
  logic [IDW-1:0] sel_idx;
  logic [7:0]     sel_dat;
  logic           grant;
  logic [IDW-1:0] rr_next;

  // Scan descending so the lowest qualifying index is the last (winning) assignment
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    hi_dat = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    lo_dat = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_vld = 1'b1;
        lo_idx = IDW'(i);
        lo_dat = req_data[8*i +: 8];
        if (i >= int'(rr_ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = IDW'(i);
          hi_dat = req_data[8*i +: 8];
        end
      end
    end
  end

  // Prefer the first requester at/after rr_ptr; otherwise wrap to the lowest index
  always_comb begin
    sel_vld = hi_vld | lo_vld;
    sel_idx = hi_vld ? hi_idx : lo_idx;
    sel_dat = hi_vld ? hi_dat : lo_dat;
    grant   = (state_q == ST_IDLE) && tx_ready && sel_vld;
    rr_next = (sel_idx == IDW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  // One-hot acceptance pulse, only while a grant is being made in IDLE
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (sel_idx == IDW'(i));
    end
  end

  // Transfer sequencer: latch byte, pulse enable, then wait for the serializer to finish
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      tx_din_q     <= '0;
      tx_enable_q  <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
      sent_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            tx_din_q     <= sel_dat;
            grant_id_q   <= sel_idx;
            rr_ptr_q     <= rr_next;
            sent_count_q <= sent_count_q + 16'd1;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tx_enable_q <= 1'b1;
          state_q     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          tx_enable_q <= 1'b0;
          state_q     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_ready) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_enable_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_din     = tx_din_q;
  assign tx_enable  = tx_enable_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign sent_count = sent_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, ordering, round-robin, backpressure, reset in WAIT, counter wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge (or #1 after an input change).
// The serializer is modelled by hand: tx_ready drops after the enable pulse and returns a few cycles later.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_din;
  logic        tx_enable;
  logic        tx_ready;
  logic        busy;
  logic [2:0]  grant_id;
  logic [15:0] sent_count;

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;
  int bad      = 0;

  logic [7:0] sent_q[$];
  logic [7:0] exp_bytes [16] = '{8'h41, 8'h10, 8'h11, 8'h12, 8'h13,
                                 8'hA0, 8'hA2, 8'hA0, 8'hA2, 8'hA0, 8'hA2,
                                 8'h5C, 8'h77, 8'h33, 8'h99, 8'hE5};

  uart_tx_arbiter #(.NUM_REQ(4), .IDW(3)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_din     (tx_din),
    .tx_enable  (tx_enable),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .grant_id   (grant_id),
    .sent_count (sent_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every byte the serializer would see, and flag illegal req_ready patterns
  always @(negedge CLK) begin
    if (tx_enable === 1'b1) sent_q.push_back(tx_din);
    if (req_ready !== 4'b0000 &&
        (busy !== 1'b0 || tx_ready !== 1'b1 || $countones(req_ready) != 1))
      viol++;
  end

  task automatic do_reset();
    @(negedge CLK);
    RST       = 1'b1;
    req_valid = 4'b0000;
    tx_ready  = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  // Called right after a falling edge in IDLE with inputs already applied
  task automatic xfer(input int id, input logic [7:0] b, input bit drop, input logic [15:0] cnt);
    #1;
    check($sformatf("req_ready_%0h", b), 32'(req_ready), 32'(1 << id));
    @(posedge CLK);
    #1;
    if (drop) req_valid[id] = 1'b0;
    @(negedge CLK);
    check("grant_id", 32'(grant_id), 32'(id));
    check("tx_din", 32'(tx_din), 32'(b));
    check("sent_count", 32'(sent_count), 32'(cnt));
    check("busy_issue", 32'(busy), 32'd1);
    check("enable_issue", 32'(tx_enable), 32'd0);
    @(negedge CLK);
    check("enable_release", 32'(tx_enable), 32'd1);
    tx_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("enable_wait", 32'(tx_enable), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    tx_ready = 1'b1;
    @(negedge CLK);
    check("busy_idle", 32'(busy), 32'd0);
    check("din_hold", 32'(tx_din), 32'(b));
  endtask

  initial begin
    RST       = 1'b1;
    tx_ready  = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0;

    // Reset values
    @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_din", 32'(tx_din), 32'd0);
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_sent_count", 32'(sent_count), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Single request
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h41;
    xfer(0, 8'h41, 1'b1, 16'd1);

    // All four valid together: served 0,1,2,3
    do_reset();
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) xfer(i, 8'h10 + 8'(i), 1'b1, 16'(i + 1));

    // req0 and req2 permanently valid: alternate 0,2,0,2,0,2
    do_reset();
    req_data  = 32'h00A200A0;
    req_valid = 4'b0101;
    for (int i = 0; i < 6; i++)
      xfer((i % 2 == 0) ? 0 : 2, (i % 2 == 0) ? 8'hA0 : 8'hA2, 1'b0, 16'(i + 1));
    req_valid = 4'b0000;

    // Backpressure: nothing granted while tx_ready is low in IDLE
    tx_ready        = 1'b0;
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h5C;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (req_ready !== 4'b0000 || tx_enable !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("backpressure_hold", 32'(bad), 32'd0);
    tx_ready = 1'b1;
    xfer(2, 8'h5C, 1'b1, 16'd7);

    // Reset while in WAIT
    req_valid      = 4'b0010;
    req_data[15:8] = 8'h77;
    #1;
    check("rw_req_ready", 32'(req_ready), 32'b0010);
    @(posedge CLK);
    #1;
    req_valid = 4'b0000;
    @(negedge CLK);
    check("rw_tx_din", 32'(tx_din), 32'h77);
    check("rw_sent_count", 32'(sent_count), 32'd8);
    @(negedge CLK);
    check("rw_enable", 32'(tx_enable), 32'd1);
    tx_ready = 1'b0;
    @(negedge CLK);
    check("rw_busy_wait", 32'(busy), 32'd1);
    #2;
    RST             = 1'b1;
    req_valid       = 4'b1001;
    req_data[7:0]   = 8'h33;
    req_data[31:24] = 8'h99;
    #1;
    check("rw_rst_busy", 32'(busy), 32'd0);
    check("rw_rst_tx_din", 32'(tx_din), 32'd0);
    check("rw_rst_grant_id", 32'(grant_id), 32'd0);
    check("rw_rst_sent_count", 32'(sent_count), 32'd0);
    check("rw_rst_enable", 32'(tx_enable), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (req_ready !== 4'b0000 || busy !== 1'b0) bad++;
    end
    check("rw_no_grant", 32'(bad), 32'd0);
    tx_ready = 1'b1;
    xfer(0, 8'h33, 1'b1, 16'd1);
    xfer(3, 8'h99, 1'b1, 16'd2);

    // Counter wrap from 0xFFFF to 0
    force dut.sent_count_q = 16'hFFFF;
    @(negedge CLK);
    release dut.sent_count_q;
    @(negedge CLK);
    check("wrap_preload", 32'(sent_count), 32'hFFFF);
    req_valid       = 4'b1000;
    req_data[31:24] = 8'hE5;
    xfer(3, 8'hE5, 1'b1, 16'h0000);

    // Byte stream seen by the serializer and protocol invariants
    repeat (2) @(negedge CLK);
    check("byte_count", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < sent_q.size()) check($sformatf("byte_%0d", i), 32'(sent_q[i]), 32'(exp_bytes[i]));
    end
    check("req_ready_protocol", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
